// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types: word/line widths and the arbiter state encoding.
package lc3b_types;

  localparam int LINE_WIDTH = 128;

  typedef logic [15:0]           lc3b_word;
  typedef logic [LINE_WIDTH-1:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } arb_state_t;

endpackage

// File: rtl/cache_arbiter_control.sv
// Arbiter FSM and grant policy. ARB_ROUND_ROBIN_EN selects alternating ties;
// otherwise D always wins a tie.
module cache_arbiter_control
  import lc3b_types::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_req,
  input  logic       d_req,
  input  logic       pmem_resp,
  output arb_state_t o_state,
  output logic       o_grant_i,
  output logic       o_grant_d,
  output logic       o_i_resp,
  output logic       o_d_resp
);

  arb_state_t r_state;
  logic       w_pick_i;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_d;

  // I wins a tie only when D was granted last.
  always_comb w_pick_i = i_req & (~d_req | r_last_d);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       r_last_d <= 1'b1;
    else if (o_grant_i) r_last_d <= 1'b0;
    else if (o_grant_d) r_last_d <= 1'b1;
  end
`else
  always_comb w_pick_i = i_req & ~d_req;
`endif

  always_comb begin
    o_grant_i = (r_state == IDLE) & w_pick_i;
    o_grant_d = (r_state == IDLE) & d_req & ~w_pick_i;
    o_i_resp  = (r_state == I_BUSY) & pmem_resp;
    o_d_resp  = (r_state == D_BUSY) & pmem_resp;
    o_state   = r_state;
  end

  // Returning to IDLE after every resp forces a turnaround cycle between grants.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (o_grant_i)      r_state <= I_BUSY;
          else if (o_grant_d) r_state <= D_BUSY;
        end
        I_BUSY, D_BUSY: if (pmem_resp) r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// Two-port (I/D cache) to single physical memory arbiter. Grant policy is
// selected by ARB_ROUND_ROBIN_EN (see cache_arbiter_control).
module cache_arbiter #(
  parameter int LINE_WIDTH = lc3b_types::LINE_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_pmem_read,
  input  logic [15:0]           i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [15:0]           d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [15:0]           pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp
);
  import lc3b_types::*;

  arb_state_t            w_state;
  logic                  w_grant_i;
  logic                  w_grant_d;
  logic [15:0]           r_addr;
  logic [LINE_WIDTH-1:0] r_wdata;
  logic                  r_write;

  cache_arbiter_control u_ctrl (
    .clk       (clk),
    .reset_n   (reset_n),
    .i_req     (i_pmem_read),
    .d_req     (d_pmem_read | d_pmem_write),
    .pmem_resp (pmem_resp),
    .o_state   (w_state),
    .o_grant_i (w_grant_i),
    .o_grant_d (w_grant_d),
    .o_i_resp  (i_pmem_resp),
    .o_d_resp  (d_pmem_resp)
  );

  // A simultaneous D read+write is latched as a write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
    end else if (w_grant_i) begin
      r_addr  <= i_pmem_address;
      r_write <= 1'b0;
    end else if (w_grant_d) begin
      r_addr  <= d_pmem_address;
      r_wdata <= d_pmem_wdata;
      r_write <= d_pmem_write;
    end
  end

  always_comb begin
    pmem_read    = (w_state == I_BUSY) | ((w_state == D_BUSY) & ~r_write);
    pmem_write   = (w_state == D_BUSY) & r_write;
    pmem_address = r_addr;
    pmem_wdata   = r_wdata;
    i_pmem_rdata = pmem_rdata;
    d_pmem_rdata = pmem_rdata;
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: directed scenarios plus random traffic
// against a transaction-level reference model.
module tb_cache_arbiter;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         i_pmem_read;
  logic [15:0]  i_pmem_address;
  logic [127:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [15:0]  d_pmem_address;
  logic [127:0] d_pmem_wdata;
  logic [127:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  always #5 clk = ~clk;

  cache_arbiter dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model: one outstanding transaction (who, where, what) or none.
  bit           m_busy;
  bit           m_side_d;
  bit           m_wr;
  bit           m_last_d;
  logic [15:0]  m_addr;
  logic [127:0] m_wdata;
  bit           seen_i, seen_d;
  int           order[$];

  task automatic model_reset();
    m_busy = 0; m_side_d = 0; m_wr = 0; m_last_d = 1;
    m_addr = '0; m_wdata = '0;
  endtask

  task automatic model_edge();
    bit ir, dr, take_d;
    ir = i_pmem_read;
    dr = d_pmem_read | d_pmem_write;
    if (m_busy) begin
      if (pmem_resp) m_busy = 0;
    end else if (ir || dr) begin
`ifdef ARB_ROUND_ROBIN_EN
      take_d = dr && (!ir || !m_last_d);
`else
      take_d = dr;
`endif
      m_busy   = 1;
      m_side_d = take_d;
      m_last_d = take_d;
      m_addr   = take_d ? d_pmem_address : i_pmem_address;
      m_wr     = take_d && d_pmem_write;
      if (take_d) m_wdata = d_pmem_wdata;
    end
  endtask

  // Check one cycle at the falling edge, then advance the model on the rising edge.
  task automatic step();
    @(negedge clk);
    chk("pmem_read",  pmem_read,   m_busy && !m_wr);
    chk("pmem_write", pmem_write,  m_busy && m_wr);
    chk("i_resp",     i_pmem_resp, m_busy && !m_side_d && pmem_resp);
    chk("d_resp",     d_pmem_resp, m_busy && m_side_d && pmem_resp);
    chk("i_rdata",    i_pmem_rdata, pmem_rdata);
    chk("d_rdata",    d_pmem_rdata, pmem_rdata);
    if (m_busy) chk("pmem_address", pmem_address, m_addr);
    if (m_busy && m_wr) chk("pmem_wdata", pmem_wdata, m_wdata);
    seen_i = i_pmem_resp;
    seen_d = d_pmem_resp;
    if (seen_i) order.push_back(0);
    if (seen_d) order.push_back(1);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic quiet();
    i_pmem_read = 0; d_pmem_read = 0; d_pmem_write = 0; pmem_resp = 0;
  endtask

  task automatic do_reset();
    reset_n = 0;
    model_reset();
    quiet();
    @(posedge clk); #1;
    reset_n = 1;
  endtask

  task automatic run_pair();
    int c;
    i_pmem_read = 1; i_pmem_address = 16'h1000;
    d_pmem_read = 1; d_pmem_address = 16'h2000;
    for (c = 0; c < 20 && (i_pmem_read || d_pmem_read); c++) begin
      pmem_resp = m_busy;
      step();
      if (seen_i) i_pmem_read = 0;
      if (seen_d) d_pmem_read = 0;
    end
    pmem_resp = 0;
    if (i_pmem_read || d_pmem_read) chk("pair_timeout", 1, 0);
  endtask

  initial begin
    int exp_order[4];
    reset_n = 0;
    i_pmem_address = '0; d_pmem_address = '0; d_pmem_wdata = '0;
    pmem_rdata = '0;
    quiet();
    model_reset();
    #12;
    chk("rst_read",  pmem_read,   0);
    chk("rst_write", pmem_write,  0);
    chk("rst_addr",  pmem_address, 0);
    chk("rst_iresp", i_pmem_resp, 0);
    chk("rst_dresp", d_pmem_resp, 0);
    @(posedge clk); #1;
    reset_n = 1;

    // I-read, memory answers on the third busy cycle.
    i_pmem_read = 1; i_pmem_address = 16'h1230;
    step();
    chk("ird_cmd",  pmem_read, 1);
    chk("ird_addr", pmem_address, 16'h1230);
    step(); step();
    pmem_resp = 1; pmem_rdata = {16{8'hAA}};
    step();
    chk("ird_iresp", seen_i, 1);
    chk("ird_dresp", seen_d, 0);
    quiet();
    step();
    chk("ird_idle", pmem_read, 0);

    // D writeback.
    d_pmem_write = 1; d_pmem_address = 16'h4560;
    d_pmem_wdata = 128'h0123456789ABCDEF0123456789ABCDEF;
    step();
    chk("dwr_cmd",   pmem_write, 1);
    chk("dwr_rd",    pmem_read, 0);
    chk("dwr_wdata", pmem_wdata, 128'h0123456789ABCDEF0123456789ABCDEF);
    pmem_resp = 1;
    step();
    chk("dwr_dresp", seen_d, 1);
    quiet();
    step();

    // Read+write together is a write.
    d_pmem_read = 1; d_pmem_write = 1; d_pmem_address = 16'h0040;
    step();
    chk("rw_write", pmem_write, 1);
    chk("rw_read",  pmem_read, 0);
    pmem_resp = 1;
    step();
    quiet();
    step();

    // Address change during D_BUSY is ignored.
    d_pmem_read = 1; d_pmem_address = 16'h2000;
    step();
    d_pmem_address = 16'h3000;
    step();
    chk("hold_addr", pmem_address, 16'h2000);
    pmem_resp = 1;
    step();
    quiet();
    step();

    // Stray resp in IDLE.
    pmem_resp = 1;
    step();
    chk("idle_iresp", seen_i, 0);
    chk("idle_dresp", seen_d, 0);
    pmem_resp = 0;
    step();
    chk("idle_stay", pmem_read | pmem_write, 0);

    // Tie-breaking, from a fresh reset.
    do_reset();
    order.delete();
    run_pair();
    step();
    run_pair();
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 1};
`else
    exp_order = '{1, 0, 1, 0};
`endif
    chk("tie_count", order.size(), 4);
    for (int k = 0; k < 4 && k < order.size(); k++)
      chk($sformatf("tie_order%0d", k), order[k], exp_order[k]);

    // Reset mid-transfer abandons the I read.
    step();
    i_pmem_read = 1; i_pmem_address = 16'h0ABC;
    step();
    step();
    #2;
    reset_n = 0; pmem_resp = 1;
    #1;
    chk("rst_mid_read",  pmem_read, 0);
    chk("rst_mid_iresp", i_pmem_resp, 0);
    model_reset();
    i_pmem_read = 0;
    @(posedge clk); #1;
    reset_n = 1; pmem_resp = 0;
    step();
    chk("rst_mid_idle", pmem_read, 0);

    // Random traffic.
    for (int n = 0; n < 500; n++) begin
      i_pmem_read    = ($urandom_range(2) == 0);
      d_pmem_read    = ($urandom_range(2) == 0);
      d_pmem_write   = ($urandom_range(3) == 0);
      i_pmem_address = 16'($urandom);
      d_pmem_address = 16'($urandom);
      d_pmem_wdata   = {$urandom, $urandom, $urandom, $urandom};
      pmem_rdata     = {$urandom, $urandom, $urandom, $urandom};
      pmem_resp      = ($urandom_range(3) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
